barrel_shift_pipe: RTL and testbench

// - Parametrised, fully pipelined barrel shifter; successor to the combinational 32-bit mux2 shifter.
// - Supports logical left, logical right and arithmetic right shifts, plus optional rotate-right.
// - Uses one register stage per shift level with a valid/ready handshake on both sides.
// - Sits between the operand-issue logic and the ALU writeback mux; carries an opaque tag for result routing.

---
 rtl/bshift_if.sv | 35 +++
 rtl/barrel_shift_pipe.sv | 95 +++++++++
 tb/tb_barrel_shift_pipe.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bshift_if.sv
// bshift_if: operand/result handshake bundle for barrel_shift_pipe.
//   master : producer/consumer side. It drives in_* and out_ready, and it observes in_ready and out_*.
//   slave  : shifter side. It drives in_ready and out_*, and it observes in_* and out_ready.
//   in_valid/in_ready   issue handshake
//   in_data/amt/op/tag  operand, shift amount, opcode, routing tag
//   out_valid/out_ready result handshake
//   out_data/tag/zero   result, returned tag, result-is-zero flag
interface bshift_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: fully pipelined barrel shifter, one register stage per shift level.
// Stage k applies a shift of 2^(SHW-1-k) when the matching amount bit is set, so the MSB level comes first.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
// The ROR op exists only when BSHIFT_ROTATE_EN is defined. Otherwise op 11 behaves as SRL.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : bshift_if.slave, which carries the in_* issue handshake and the out_* result handshake
// The pipeline stalls as a whole when the final stage holds a result that the consumer does not take.
// in_ready is the inverse of that stall.
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  bshift_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef BSHIFT_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic             sign;   // original operand MSB, used as the SRA fill bit
  } stage_t;

  stage_t         st_q [SHW];
  stage_t         st_d [SHW];
  logic [SHW-1:0] vld_pipe;
  logic           zero_q;
  logic           stall;

  assign stall        = vld_pipe[SHW-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Each level reads the previous stage register (level 0 reads the issue port).
  // The level then applies its fixed power-of-two shift when its amount bit is set.
  always_comb begin
    stage_t cur;
    int     sh;
    cur = '0;
    sh  = 0;
    for (int k = 0; k < SHW; k++) begin
      if (k == 0) begin
        cur.data = bus.in_data;
        cur.amt  = bus.in_amt;
        cur.op   = bus.in_op;
        cur.tag  = bus.in_tag;
        cur.sign = bus.in_data[WIDTH-1];
      end else begin
        cur = st_q[k-1];
      end
      sh      = 1 << (SHW - 1 - k);
      st_d[k] = cur;
      if (cur.amt[SHW-1-k]) begin
        case (cur.op)
          OP_SLL:  st_d[k].data = cur.data << sh;
          OP_SRL:  st_d[k].data = cur.data >> sh;
          OP_SRA:  st_d[k].data = (cur.data >> sh) |
                                  ({WIDTH{cur.sign}} & ~({WIDTH{1'b1}} >> sh));
`ifdef BSHIFT_ROTATE_EN
          OP_ROR:  st_d[k].data = (cur.data >> sh) | (cur.data << (WIDTH - sh));
`endif
          default: st_d[k].data = cur.data >> sh;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      zero_q   <= 1'b0;
      for (int k = 0; k < SHW; k++) st_q[k] <= '0;
    end else if (!stall) begin
      // Empty slots advance as bubbles, and their data is don't-care.
      vld_pipe <= {vld_pipe[SHW-2:0], bus.in_valid};
      for (int k = 0; k < SHW; k++) st_q[k] <= st_d[k];
      zero_q   <= (st_d[SHW-1].data == '0);
    end
  end

  assign bus.out_valid = vld_pipe[SHW-1];
  assign bus.out_data  = st_q[SHW-1].data;
  assign bus.out_tag   = st_q[SHW-1].tag;
  assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe (WIDTH=32, TAG_W=4).
module tb_barrel_shift_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

`ifdef BSHIFT_ROTATE_EN
  localparam logic [31:0] ROR8 = 32'h19D011E0;
  localparam logic [31:0] ROR1 = 32'h80000000;
`else
  localparam logic [31:0] ROR8 = 32'h00D011E0;
  localparam logic [31:0] ROR1 = 32'h00000000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bshift_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

  barrel_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        zero;
    int          pres;    // cycle in which the op was accepted
    bit          lat;     // check issue-to-output latency
    bit          consec;  // must follow the previous result by exactly one cycle
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] e;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  vec_t vecs [13] = '{
    '{32'hD011E019, 5'd4,  2'b10, 4'd3,  32'hFD011E01},
    '{32'hD011E019, 5'd8,  2'b00, 4'd1,  32'h11E01900},
    '{32'hD011E019, 5'd16, 2'b01, 4'd2,  32'h0000D011},
    '{32'h7FFFFFFF, 5'd31, 2'b10, 4'd4,  32'h00000000},
    '{32'hD011E019, 5'd8,  2'b11, 4'd5,  ROR8},
    '{32'hD011E019, 5'd0,  2'b00, 4'd6,  32'hD011E019},
    '{32'h80000001, 5'd0,  2'b10, 4'd7,  32'h80000001},
    '{32'hD011E019, 5'd0,  2'b11, 4'd8,  32'hD011E019},
    '{32'h80000000, 5'd31, 2'b10, 4'd9,  32'hFFFFFFFF},
    '{32'h00000001, 5'd31, 2'b00, 4'd10, 32'h80000000},
    '{32'h80000000, 5'd31, 2'b01, 4'd11, 32'h00000001},
    '{32'h00000001, 5'd1,  2'b11, 4'd12, ROR1},
    '{32'h80000000, 5'd1,  2'b00, 4'd13, 32'h00000000}
  };

  logic [31:0] b2b_exp [8] = '{32'h3, 32'h6, 32'hC, 32'h18, 32'h30, 32'h60, 32'hC0, 32'h180};
  logic [31:0] bp_exp  [6] = '{32'h80000000, 32'hC0000000, 32'hE0000000,
                               32'hF0000000, 32'hF8000000, 32'hFC000000};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got tag %0d data %h, expected no result", bus.out_tag, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_tag",  bus.out_tag,  e.tag);
        chk("out_zero", bus.out_zero, e.zero);
        if (e.lat)    chk("latency", cyc - e.pres, 5);
        if (e.consec) chk("consecutive", cyc - last_cyc, 1);
      end
      last_cyc = cyc;
    end
  end

  // Called just after a rising edge. Returns just after the rising edge that accepted the op.
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                      input logic [3:0] tag, input logic [31:0] e, input bit lat, input bit consec);
    exp_t x;
    int   tries;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = op;
    bus.in_tag   = tag;
    tries = 0;
    @(negedge clk);
    while (!bus.in_ready && tries < 50) begin
      tries++;
      @(negedge clk);
    end
    chk("in_ready_wait", bus.in_ready, 1);
    if (bus.in_ready) begin
      x.data = e; x.tag = tag; x.zero = (e == 32'h0);
      x.pres = cyc; x.lat = lat; x.consec = consec;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap_d;
    logic [3:0]  snap_t;
    logic        snap_z;
    int          w;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_op = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_tag",   bus.out_tag,   0);
    chk("rst_out_zero",  bus.out_zero,  0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);
    @(posedge clk); #2;

    // Directed vectors. The first one goes alone, and the rest go back-to-back.
    send(vecs[0].d, vecs[0].a, vecs[0].op, vecs[0].tag, vecs[0].e, 1, 0);
    idle(8);
    for (int i = 1; i < 13; i++)
      send(vecs[i].d, vecs[i].a, vecs[i].op, vecs[i].tag, vecs[i].e, 1, 0);
    idle(8);

    // Back-to-back: tags 0..7, results must come on consecutive cycles.
    for (int i = 0; i < 8; i++)
      send(32'h3, 5'(i), 2'b00, 4'(i), b2b_exp[i], 1, i != 0);
    idle(10);

    // Backpressure: consumer stalls while the pipe is full. The sixth op must wait.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h80000000, 5'(i), 2'b10, 4'(10 + i), bp_exp[i], 0, 0);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 20) begin
          w++;
          @(negedge clk);
        end
        chk("bp_out_valid", bus.out_valid, 1);
        snap_d = bus.out_data; snap_t = bus.out_tag; snap_z = bus.out_zero;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready",  bus.in_ready,  0);
          chk("bp_out_valid_hold", bus.out_valid, 1);
          chk("bp_data_hold", bus.out_data,  snap_d);
          chk("bp_tag_hold",  bus.out_tag,   snap_t);
          chk("bp_zero_hold", bus.out_zero,  snap_z);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
      end
    join
    idle(12);
    chk("bp_all_drained", exp_q.size(), 0);

    // Reset mid-stream: three ops in flight, and the oldest is at the output.
    for (int i = 0; i < 3; i++)
      send(32'h0000FFFF, 5'd4, 2'b00, 4'(i), 32'h000FFFF0, 0, 0);
    idle(2);
    chk("flight_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data",  bus.out_data,  0);
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_no_valid", bus.out_valid, 0);
    @(posedge clk); #2;
    send(32'hD011E019, 5'd4, 2'b10, 4'd9, 32'hFD011E01, 1, 0);

    // Drain
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    idle(3);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
